// File: rtl/bn_pkg.sv
// Shared types and constants for the batch-normalisation sequencer.
// Factor codes select the scaling of z applied by the datapath.
package bn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CALC,
    ST_WRITE,
    ST_DONE
  } bn_state_e;

  localparam logic [3:0] BN_X1    = 4'b0100;
  localparam logic [3:0] BN_X0_25 = 4'b1000;
  localparam logic [3:0] BN_X4    = 4'b1100;
  localparam logic [3:0] BN_X0_5  = 4'b0001;
  localparam logic [3:0] BN_X2    = 4'b0010;
  localparam logic [3:0] BN_X8    = 4'b0011;

  // Reserved codes are never stored; they are replaced by pass-through.
  function automatic logic bn_code_reserved(input logic [3:0] code);
    return code inside {4'b0111, 4'b1011, 4'b1111, 4'b0000};
  endfunction

  // x8 already uses the full headroom, so it may not be combined with an addend.
  function automatic logic bn_factor_legal(input logic [3:0] code, input int addend);
    return !bn_code_reserved(code) && !((code == BN_X8) && (addend != 0));
  endfunction

endpackage

// File: rtl/batch_normalization.sv
// BN datapath: result = sat(u + scale(z) + addend), with fractional scales
// rounding toward minus infinity. Unknown codes fall back to pass-through.
module batch_normalization
  import bn_pkg::*;
#(
  parameter int WIDTH        = 6,
  parameter int ADDEND_WIDTH = WIDTH - 2
) (
  input  logic signed [WIDTH-1:0]        u,
  input  logic signed [WIDTH-1:0]        z,
  input  logic        [3:0]              factor,
  input  logic signed [ADDEND_WIDTH-1:0] addend,
  output logic signed [WIDTH-1:0]        result
);

  // Wide enough for z*8 plus two more additions without overflow.
  localparam int EW = WIDTH + 5;
  localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_MIN = EW'(-(2 ** (WIDTH - 1)));

  logic signed [EW-1:0] u_x, z_x, a_x, z_scaled, sum;

  always_comb begin
    u_x = EW'(u);
    z_x = EW'(z);
    a_x = EW'(addend);
    case (factor)
      BN_X0_25: z_scaled = z_x >>> 2;
      BN_X0_5:  z_scaled = z_x >>> 1;
      BN_X2:    z_scaled = z_x <<< 1;
      BN_X4:    z_scaled = z_x <<< 2;
      BN_X8:    z_scaled = z_x <<< 3;
      default:  z_scaled = z_x;
    endcase
    sum = u_x + z_scaled + a_x;
    if (sum > SAT_MAX)      result = SAT_MAX[WIDTH-1:0];
    else if (sum < SAT_MIN) result = SAT_MIN[WIDTH-1:0];
    else                    result = sum[WIDTH-1:0];
  end

endmodule

// File: rtl/bn_sequencer_cfg_regfile.sv
// Per-neuron BN configuration: sanitise-on-write, combinational read,
// sticky error flag for any write that had to be altered or dropped.
module bn_cfg_regfile
  import bn_pkg::*;
#(
  parameter int N_NEURONS    = 8,
  parameter int ADDR_W       = 3,
  parameter int ADDEND_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic        [ADDR_W-1:0]       wr_addr,
  input  logic        [3:0]              wr_factor,
  input  logic signed [ADDEND_WIDTH-1:0] wr_addend,
  input  logic        [ADDR_W-1:0]       rd_addr,
  output logic        [3:0]              rd_factor,
  output logic signed [ADDEND_WIDTH-1:0] rd_addend,
  output logic                           err
);

  typedef struct packed {
    logic        [3:0]              factor;
    logic signed [ADDEND_WIDTH-1:0] addend;
  } cfg_entry_t;

  // Sized to the address space so any address indexes safely; only the
  // first N_NEURONS entries are ever written.
  cfg_entry_t entries [2**ADDR_W];
  cfg_entry_t wr_entry;
  logic       in_range;
  logic       legal;

  always_comb begin
    in_range        = int'(wr_addr) < N_NEURONS;
    legal           = bn_factor_legal(wr_factor, int'(wr_addend));
    wr_entry.factor = wr_factor;
    wr_entry.addend = wr_addend;
    if (bn_code_reserved(wr_factor)) wr_entry.factor = BN_X1;
    else if (!legal)                 wr_entry.addend = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
      // NOTE: this small register file is reset, unlike a RAM, so every neuron
      // comes up as pass-through without a software init sequence.
      for (int i = 0; i < 2**ADDR_W; i++) entries[i] <= '{factor: BN_X1, addend: '0};
    end else if (we) begin
      if (!in_range || !legal) err <= 1'b1;
      if (in_range) entries[wr_addr] <= wr_entry;
    end
  end

  assign rd_factor = entries[rd_addr].factor;
  assign rd_addend = entries[rd_addr].addend;

endmodule

// File: rtl/bn_sequencer.sv
// Time-multiplexes one batch_normalization datapath over N_NEURONS neurons:
// READ -> CALC -> WRITE per neuron, then a one-cycle DONE.
module bn_sequencer
  import bn_pkg::*;
#(
  parameter int WIDTH        = 6,
  parameter int ADDEND_WIDTH = WIDTH - 2,
  parameter int N_NEURONS    = 8,
  parameter int ADDR_W       = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_we,
  input  logic        [ADDR_W-1:0]       cfg_addr,
  input  logic        [3:0]              cfg_factor,
  input  logic signed [ADDEND_WIDTH-1:0] cfg_addend,
  output logic                           cfg_err,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           mem_rd_en,
  output logic                           mem_wr_en,
  output logic        [ADDR_W-1:0]       mem_addr,
  input  logic signed [WIDTH-1:0]        u_in,
  input  logic signed [WIDTH-1:0]        z_in,
  output logic signed [WIDTH-1:0]        u_out
);

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(N_NEURONS - 1);

  bn_state_e                      state, state_nxt;
  logic        [ADDR_W-1:0]       index, index_nxt;
  logic        [3:0]              cur_factor;
  logic signed [ADDEND_WIDTH-1:0] cur_addend;
  logic signed [WIDTH-1:0]        bn_result;

  // Config is writable only while idle, so a run always sees a stable table.
  bn_cfg_regfile #(
    .N_NEURONS    (N_NEURONS),
    .ADDR_W       (ADDR_W),
    .ADDEND_WIDTH (ADDEND_WIDTH)
  ) u_cfg (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (cfg_we && (state == ST_IDLE)),
    .wr_addr   (cfg_addr),
    .wr_factor (cfg_factor),
    .wr_addend (cfg_addend),
    .rd_addr   (index),
    .rd_factor (cur_factor),
    .rd_addend (cur_addend),
    .err       (cfg_err)
  );

  batch_normalization #(
    .WIDTH        (WIDTH),
    .ADDEND_WIDTH (ADDEND_WIDTH)
  ) u_bn (
    .u      (u_in),
    .z      (z_in),
    .factor (cur_factor),
    .addend (cur_addend),
    .result (bn_result)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the combinational block below uses blocking ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      index <= '0;
      u_out <= '0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
      if (state == ST_CALC) u_out <= bn_result;
    end
  end

  // NOTE: defaults first, so no path through the case leaves a signal unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    index_nxt = index;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_READ;
          index_nxt = '0;
        end
      end
      ST_READ:  state_nxt = ST_CALC;
      ST_CALC:  state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (index == LAST_INDEX) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_READ;
          index_nxt = index + 1'b1;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = state inside {ST_READ, ST_CALC, ST_WRITE};
  assign done      = (state == ST_DONE);
  assign mem_rd_en = (state == ST_READ);
  assign mem_wr_en = (state == ST_WRITE);
  assign mem_addr  = index;

endmodule

// File: tb/tb_bn_sequencer.sv
// Self-checking bench for bn_sequencer: neuron-state memory responder,
// spec-level BN model, per-write compare process and directed runs.
module tb_bn_sequencer;
  import bn_pkg::*;

  localparam int WIDTH  = 6;
  localparam int AW     = WIDTH - 2;
  localparam int N      = 8;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                     cfg_we = 1'b0;
  logic        [ADDR_W-1:0] cfg_addr = '0;
  logic        [3:0]        cfg_factor = '0;
  logic signed [AW-1:0]     cfg_addend = '0;
  logic                     cfg_err;
  logic                     start = 1'b0;
  logic                     busy, done, mem_rd_en, mem_wr_en;
  logic        [ADDR_W-1:0] mem_addr;
  logic signed [WIDTH-1:0]  u_in = '0, z_in = '0, u_out;

  bn_sequencer #(.WIDTH(WIDTH), .ADDEND_WIDTH(AW), .N_NEURONS(N), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_factor(cfg_factor),
    .cfg_addend(cfg_addend), .cfg_err(cfg_err), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .u_in(u_in), .z_in(z_in), .u_out(u_out)
  );

  // Second instance with a wider address so an out-of-range index is expressible.
  logic                    cfg_we2 = 1'b0, start2 = 1'b0;
  logic        [3:0]       cfg_addr2 = '0, mem_addr2;
  logic        [3:0]       cfg_factor2 = '0;
  logic signed [AW-1:0]    cfg_addend2 = '0;
  logic                    cfg_err2, busy2, done2, mem_rd_en2, mem_wr_en2;
  logic signed [WIDTH-1:0] u_in2 = 6'sd1, z_in2 = 6'sd1, u_out2;

  bn_sequencer #(.WIDTH(WIDTH), .ADDEND_WIDTH(AW), .N_NEURONS(N), .ADDR_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we2), .cfg_addr(cfg_addr2), .cfg_factor(cfg_factor2),
    .cfg_addend(cfg_addend2), .cfg_err(cfg_err2), .start(start2), .busy(busy2), .done(done2),
    .mem_rd_en(mem_rd_en2), .mem_wr_en(mem_wr_en2), .mem_addr(mem_addr2),
    .u_in(u_in2), .z_in(z_in2), .u_out(u_out2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Neuron-state memory: init_* is what each run reads, wb_u collects write-backs.
  int init_u [N];
  int init_z [N];
  int wb_u   [N];

  always @(posedge clk) begin
    if (mem_rd_en) begin
      u_in <= WIDTH'(init_u[mem_addr]);
      z_in <= WIDTH'(init_z[mem_addr]);
    end
    if (mem_wr_en) wb_u[mem_addr] <= int'(u_out);
  end

  // Config model
  logic [3:0] m_factor [N];
  int         m_addend [N];
  bit         m_err;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_factor[i] = 4'b0100;
      m_addend[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic void model_cfg(input int addr, input logic [3:0] f, input int a);
    if (addr >= N) begin
      m_err = 1'b1;
    end else if (f == 4'b0111 || f == 4'b1011 || f == 4'b1111 || f == 4'b0000) begin
      m_factor[addr] = 4'b0100;
      m_addend[addr] = a;
      m_err = 1'b1;
    end else if (f == 4'b0011 && a != 0) begin
      m_factor[addr] = f;
      m_addend[addr] = 0;
      m_err = 1'b1;
    end else begin
      m_factor[addr] = f;
      m_addend[addr] = a;
    end
  endfunction

  function automatic int floor_div(input int n, input int d);
    int q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int bn_model(input int u, input int z, input logic [3:0] f, input int a);
    int scaled, s;
    case (f)
      4'b1000: scaled = floor_div(z, 4);
      4'b0001: scaled = floor_div(z, 2);
      4'b0010: scaled = z * 2;
      4'b1100: scaled = z * 4;
      4'b0011: scaled = z * 8;
      default: scaled = z;
    endcase
    s = u + scaled + a;
    if (s > 31)  s = 31;
    if (s < -32) s = -32;
    return s;
  endfunction

  // Compare process: every write-back must hit the next neuron with the model value.
  int exp_val [N];
  int wr_idx = 0, wr_count = 0, done_count = 0, done_cyc = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_wr_exclusive", int'(mem_rd_en & mem_wr_en), 0);
      if (mem_wr_en) begin
        check("wr_addr", int'(mem_addr), wr_idx);
        if (wr_idx < N) check("wr_data", int'(u_out), exp_val[wr_idx]);
        wr_idx++;
        wr_count++;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  int wr2 = 0, bad2 = 0, done2_count = 0;
  always @(negedge clk) begin
    if (rst_n && mem_wr_en2) begin
      wr2++;
      if (u_out2 != 6'sd2) bad2++;
    end
    if (rst_n && done2) done2_count++;
  end

  task automatic cfg_write(input int addr, input logic [3:0] f, input int a);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr[ADDR_W-1:0]; cfg_factor = f; cfg_addend = a[AW-1:0];
    @(negedge clk);
    cfg_we = 1'b0;
    model_cfg(addr, f, a);
    check("cfg_err_after_write", int'(cfg_err), int'(m_err));
  endtask

  task automatic compute_expected();
    for (int i = 0; i < N; i++) exp_val[i] = bn_model(init_u[i], init_z[i], m_factor[i], m_addend[i]);
  endtask

  task automatic arm_counters();
    @(posedge clk); #1;
    wr_idx = 0; wr_count = 0; done_count = 0; done_cyc = -1;
  endtask

  // One full run; optional config write in the start cycle and optional
  // start/config pokes while busy.
  task automatic do_run(input bit cfg_same, input int ca, input logic [3:0] cf, input int cad,
                        input bit poke);
    int s0, waited;
    if (cfg_same) model_cfg(ca, cf, cad);
    compute_expected();
    arm_counters();
    @(negedge clk);
    s0 = cyc;
    start = 1'b1;
    if (cfg_same) begin
      cfg_we = 1'b1; cfg_addr = ca[ADDR_W-1:0]; cfg_factor = cf; cfg_addend = cad[AW-1:0];
    end
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    check("busy_after_start", int'(busy), 1);
    waited = 0;
    while (done_count == 0 && waited < 200) begin
      @(negedge clk);
      waited++;
      start  = poke && (cyc == s0 + 5);
      cfg_we = poke && (cyc == s0 + 8);
      if (cfg_we) begin
        cfg_addr = '0; cfg_factor = BN_X4; cfg_addend = '0;
      end
    end
    start = 1'b0; cfg_we = 1'b0;
    check("done_seen", done_count, 1);
    check("done_latency", done_cyc - s0, 3 * N + 1);
    repeat (8) @(negedge clk);
    check("single_done", done_count, 1);
    check("write_count", wr_count, N);
    check("idle_after_run", int'(busy), 0);
  endtask

  initial begin
    int s0, waited;
    init_u = '{10, 4, 30, -20, 7, -5, 12, -8};
    init_z = '{5, 3, 20, -10, -3, 2, -7, 6};
    for (int i = 0; i < N; i++) wb_u[i] = 99;
    model_reset();

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(mem_rd_en), 0);
    check("rst_wr_en", int'(mem_wr_en), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_u_out", int'(u_out), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_cfg_err2", int'(cfg_err2), 0);

    // Run 1: reset configuration is pass-through everywhere.
    do_run(1'b0, 0, 4'b0, 0, 1'b0);
    check("run1_n0_literal", wb_u[0], 15);
    check("cfg_err_still_clear", int'(cfg_err), 0);

    // Configuration, including the sanitised cases.
    cfg_write(1, 4'b0111, 0);
    check("cfg_err_reserved_literal", int'(cfg_err), 1);
    cfg_write(2, BN_X4, 0);
    cfg_write(3, BN_X4, 0);
    cfg_write(4, BN_X0_5, 0);
    cfg_write(5, BN_X8, 2);
    cfg_write(6, BN_X0_25, -2);

    // Run 2: config write in the start cycle, plus start/config pokes while busy.
    do_run(1'b1, 7, BN_X2, 3, 1'b1);
    check("run2_n1_literal", wb_u[1], 7);
    check("run2_n2_pos_sat", wb_u[2], 31);
    check("run2_n3_neg_sat", wb_u[3], -32);
    check("run2_n4_half", wb_u[4], 5);
    check("run2_n5_x8_addend_zeroed", wb_u[5], 11);
    check("run2_n6_quarter", wb_u[6], 8);
    check("run2_n7_same_cycle_cfg", wb_u[7], 7);

    // Run 3: the busy-time write to neuron 0 must not have landed.
    do_run(1'b0, 0, 4'b0, 0, 1'b0);
    check("run3_n0_unchanged", wb_u[0], 15);

    // Out-of-range config address on the wide-address instance.
    @(negedge clk);
    cfg_we2 = 1'b1; cfg_addr2 = 4'd9; cfg_factor2 = BN_X4; cfg_addend2 = '0;
    @(negedge clk);
    cfg_we2 = 1'b0;
    check("oor_cfg_err", int'(cfg_err2), 1);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    waited = 0;
    while (done2_count == 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("oor_done", done2_count, 1);
    check("oor_writes", wr2, N);
    check("oor_no_alias", bad2, 0);

    // Reset during WRITE of neuron 4.
    compute_expected();
    arm_counters();
    @(negedge clk);
    s0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s0 + 15) @(negedge clk);
    check("mid_write_en", int'(mem_wr_en), 1);
    check("mid_write_addr", int'(mem_addr), 4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("abort_busy", int'(busy), 0);
    check("abort_u_out", int'(u_out), 0);
    check("abort_cfg_err", int'(cfg_err), 0);
    repeat (30) @(negedge clk);
    check("abort_no_done", done_count, 0);
    check("abort_idle", int'(busy), 0);

    // Run after abort restarts at neuron 0 with the reset configuration.
    do_run(1'b0, 0, 4'b0, 0, 1'b0);
    check("post_reset_n2_literal", wb_u[2], 31);
    check("post_reset_n6_literal", wb_u[6], 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
